axi4_lite_slave_v2: RTL and testbench

Parametrised AXI4-Lite slave front end bridging a PS general-purpose AXI port to a simple strobe-based register interface on the accelerator side. Successor to the first-generation strobe slave: accepts AW and W independently in any order, honours BREADY/RREADY back-pressure, forwards byte strobes, rejects out-of-window addresses with DECERR and supports a fixed downstream read latency. Sits between the interconnect and the accelerator's register file.

---
 rtl/axi4_lite_slave_v2_pkg.sv | 25 ++
 rtl/axi4_lite_slave_v2_if.sv | 34 +++
 rtl/axi4_lite_slave_v2_addr_decode.sv | 23 ++
 rtl/axi4_lite_slave_v2.sv | 248 ++++++++++++++++++++++++
 tb/tb_axi4_lite_slave_v2.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_lite_slave_v2_pkg.sv
// Shared response codes and FSM state types for the AXI4-Lite strobe slave.
package axi4_lite_slave_v2_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        WrIdle,
        WrStrobe,
        WrResp
    } wr_state_e;

    typedef enum logic [1:0] {
        RdIdle,
        RdStrobe,
        RdWait,
        RdResp
    } rd_state_e;

    function automatic logic [1:0] resp_for(input logic in_range);
        return in_range ? RESP_OKAY : RESP_DECERR;
    endfunction

endpackage

// File: rtl/axi4_lite_slave_v2_if.sv
// AXI4-Lite bus bundle between the interconnect (master) and the strobe slave.
interface axi4_lite_slave_v2_if #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
);
    logic [AddrWidth-1:0]   awaddr;
    logic                   awvalid;
    logic                   awready;
    logic [DataWidth-1:0]   wdata;
    logic [DataWidth/8-1:0] wstrb;
    logic                   wvalid;
    logic                   wready;
    logic [1:0]             bresp;
    logic                   bvalid;
    logic                   bready;
    logic [AddrWidth-1:0]   araddr;
    logic                   arvalid;
    logic                   arready;
    logic [DataWidth-1:0]   rdata;
    logic [1:0]             rresp;
    logic                   rvalid;
    logic                   rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axi4_lite_slave_v2_addr_decode.sv
// Window range check and byte-address to word-offset conversion for one address channel.
module axi4_lite_slave_v2_addr_decode #(
    parameter int unsigned          AddrWidth = 32,
    parameter int unsigned          DataWidth = 32,
    parameter logic [AddrWidth-1:0] BaseAddr  = 32'h4000_0000,
    parameter logic [AddrWidth-1:0] HighAddr  = 32'h4001_ffff
) (
    input  logic [AddrWidth-1:0] addr_i,
    output logic                 in_range_o,
    output logic [AddrWidth-1:0] offset_o
);

    localparam int unsigned LaneBits = $clog2(DataWidth / 8);

    logic [AddrWidth-1:0] rel;

    always_comb begin
        in_range_o = (addr_i >= BaseAddr) && (addr_i <= HighAddr);
        rel        = addr_i - BaseAddr;
        offset_o   = rel >> LaneBits;
    end

endmodule

// File: rtl/axi4_lite_slave_v2.sv
// AXI4-Lite slave bridging to a strobe register interface; independent read and write
// FSMs, one outstanding transaction per direction, all outputs registered.
module axi4_lite_slave_v2
    import axi4_lite_slave_v2_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR         = 32'h4000_0000,
    parameter logic [31:0] C_HIGHADDR         = 32'h4001_ffff,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_READ_LATENCY     = 1
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    axi4_lite_slave_v2_if.slave             s_axi,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]   set_addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   set_data,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0] set_wstrb,
    output logic                            set_stb,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]   get_addr,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   get_data,
    output logic                            get_stb
);

    localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
    localparam int unsigned SW = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [2:0]  ReadLatency = 3'(C_READ_LATENCY);

    logic          aw_in_range, ar_in_range;
    logic [AW-1:0] aw_offset, ar_offset;

    axi4_lite_slave_v2_addr_decode #(
        .AddrWidth(AW),
        .DataWidth(DW),
        .BaseAddr (C_BASEADDR),
        .HighAddr (C_HIGHADDR)
    ) u_aw_decode (
        .addr_i    (s_axi.awaddr),
        .in_range_o(aw_in_range),
        .offset_o  (aw_offset)
    );

    axi4_lite_slave_v2_addr_decode #(
        .AddrWidth(AW),
        .DataWidth(DW),
        .BaseAddr (C_BASEADDR),
        .HighAddr (C_HIGHADDR)
    ) u_ar_decode (
        .addr_i    (s_axi.araddr),
        .in_range_o(ar_in_range),
        .offset_o  (ar_offset)
    );

    wr_state_e     wr_state_q, wr_state_d;
    logic          aw_held_q, aw_held_d, w_held_q, w_held_d, wr_ok_q, wr_ok_d;
    logic          awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [1:0]    bresp_q, bresp_d;
    logic          set_stb_q, set_stb_d;
    logic [AW-1:0] set_addr_q, set_addr_d;
    logic [DW-1:0] set_data_q, set_data_d;
    logic [SW-1:0] set_wstrb_q, set_wstrb_d;

    always_comb begin
        wr_state_d  = wr_state_q;
        aw_held_d   = aw_held_q;
        w_held_d    = w_held_q;
        wr_ok_d     = wr_ok_q;
        awready_d   = awready_q;
        wready_d    = wready_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        set_stb_d   = 1'b0;
        set_addr_d  = set_addr_q;
        set_data_d  = set_data_q;
        set_wstrb_d = set_wstrb_q;
        unique case (wr_state_q)
            WrIdle: begin
                if (s_axi.awvalid && awready_q) begin
                    aw_held_d  = 1'b1;
                    wr_ok_d    = aw_in_range;
                    set_addr_d = aw_offset;
                end
                if (s_axi.wvalid && wready_q) begin
                    w_held_d    = 1'b1;
                    set_data_d  = s_axi.wdata;
                    set_wstrb_d = s_axi.wstrb;
                end
                awready_d = !aw_held_d;
                wready_d  = !w_held_d;
                if (aw_held_d && w_held_d) begin
                    wr_state_d = WrStrobe;
                    set_stb_d  = wr_ok_d;
                    awready_d  = 1'b0;
                    wready_d   = 1'b0;
                end
            end
            WrStrobe: begin
                wr_state_d = WrResp;
                bvalid_d   = 1'b1;
                bresp_d    = resp_for(wr_ok_q);
            end
            WrResp: begin
                if (s_axi.bready) begin
                    wr_state_d = WrIdle;
                    bvalid_d   = 1'b0;
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    awready_d  = 1'b1;
                    wready_d   = 1'b1;
                end
            end
            default: wr_state_d = WrIdle;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            wr_state_q  <= WrIdle;
            aw_held_q   <= 1'b0;
            w_held_q    <= 1'b0;
            wr_ok_q     <= 1'b0;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
            set_stb_q   <= 1'b0;
            set_addr_q  <= '0;
            set_data_q  <= '0;
            set_wstrb_q <= '0;
        end else begin
            wr_state_q  <= wr_state_d;
            aw_held_q   <= aw_held_d;
            w_held_q    <= w_held_d;
            wr_ok_q     <= wr_ok_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            set_stb_q   <= set_stb_d;
            set_addr_q  <= set_addr_d;
            set_data_q  <= set_data_d;
            set_wstrb_q <= set_wstrb_d;
        end
    end

    rd_state_e     rd_state_q, rd_state_d;
    logic          rd_ok_q, rd_ok_d, arready_q, arready_d, rvalid_q, rvalid_d;
    logic          get_stb_q, get_stb_d, rd_capture;
    logic [2:0]    rd_cnt_q, rd_cnt_d;
    logic [1:0]    rresp_q, rresp_d;
    logic [AW-1:0] get_addr_q, get_addr_d;
    logic [DW-1:0] rdata_q, rdata_d;

    always_comb begin
        rd_state_d = rd_state_q;
        rd_ok_d    = rd_ok_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;
        rd_cnt_d   = rd_cnt_q;
        get_addr_d = get_addr_q;
        get_stb_d  = 1'b0;
        rd_capture = 1'b0;
        unique case (rd_state_q)
            RdIdle: begin
                if (s_axi.arvalid && arready_q) begin
                    rd_state_d = RdStrobe;
                    rd_ok_d    = ar_in_range;
                    get_addr_d = ar_offset;
                    get_stb_d  = ar_in_range;
                    arready_d  = 1'b0;
                end else begin
                    arready_d = 1'b1;
                end
            end
            RdStrobe: begin
                rd_cnt_d = ReadLatency;
                if (ReadLatency == 3'd0) begin
                    rd_capture = 1'b1;
                end else begin
                    rd_state_d = RdWait;
                end
            end
            RdWait: begin
                rd_cnt_d = rd_cnt_q - 3'd1;
                if (rd_cnt_q == 3'd1) begin
                    rd_capture = 1'b1;
                end
            end
            RdResp: begin
                if (s_axi.rready) begin
                    rd_state_d = RdIdle;
                    rvalid_d   = 1'b0;
                    arready_d  = 1'b1;
                end
            end
            default: rd_state_d = RdIdle;
        endcase
        // Out-of-window reads return zero data regardless of what get_data carries.
        if (rd_capture) begin
            rd_state_d = RdResp;
            rvalid_d   = 1'b1;
            rresp_d    = resp_for(rd_ok_q);
            rdata_d    = rd_ok_q ? get_data : '0;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            rd_state_q <= RdIdle;
            rd_ok_q    <= 1'b0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
            rd_cnt_q   <= '0;
            get_addr_q <= '0;
            get_stb_q  <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_ok_q    <= rd_ok_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            rd_cnt_q   <= rd_cnt_d;
            get_addr_q <= get_addr_d;
            get_stb_q  <= get_stb_d;
        end
    end

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rdata   = rdata_q;
    assign set_stb       = set_stb_q;
    assign set_addr      = set_addr_q;
    assign set_data      = set_data_q;
    assign set_wstrb     = set_wstrb_q;
    assign get_stb       = get_stb_q;
    assign get_addr      = get_addr_q;

endmodule

// File: tb/tb_axi4_lite_slave_v2.sv
// Directed plus randomized bench for axi4_lite_slave_v2 against a transaction-level model.
module tb_axi4_lite_slave_v2;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] HIGH = 32'h4001_ffff;
    localparam int          LAT  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] set_addr, set_data, get_addr, get_data;
    logic [3:0]  set_wstrb;
    logic        set_stb, get_stb;

    axi4_lite_slave_v2_if #(.AddrWidth(32), .DataWidth(32)) bus ();

    axi4_lite_slave_v2 #(
        .C_BASEADDR        (BASE),
        .C_HIGHADDR        (HIGH),
        .C_S_AXI_ADDR_WIDTH(32),
        .C_S_AXI_DATA_WIDTH(32),
        .C_READ_LATENCY    (LAT)
    ) dut (
        .S_AXI_ACLK  (clk),
        .S_AXI_ARESET(rst),
        .s_axi       (bus.slave),
        .set_addr    (set_addr),
        .set_data    (set_data),
        .set_wstrb   (set_wstrb),
        .set_stb     (set_stb),
        .get_addr    (get_addr),
        .get_data    (get_data),
        .get_stb     (get_stb)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Accelerator-side register file and strobe monitors.
    int          set_cnt = 0, get_cnt = 0, set_cyc = 0, get_cyc = 0;
    logic [31:0] mon_set_addr = '0, mon_set_data = '0, mon_get_addr = '0;
    logic [3:0]  mon_set_wstrb = '0;
    logic [31:0] regs [256] = '{default: 32'h0};
    logic [7:0]  stb_hist = '0;
    logic [31:0] ahist [8] = '{default: 32'h0};

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        stb_hist <= {stb_hist[6:0], get_stb};
        ahist[0] <= get_addr;
        for (int i = 1; i < 8; i++) ahist[i] <= ahist[i-1];
        if (set_stb) begin
            set_cnt       <= set_cnt + 1;
            set_cyc       <= cyc;
            mon_set_addr  <= set_addr;
            mon_set_data  <= set_data;
            mon_set_wstrb <= set_wstrb;
            for (int b = 0; b < 4; b++)
                if (set_wstrb[b]) regs[set_addr[7:0]][8*b +: 8] <= set_data[8*b +: 8];
        end
        if (get_stb) begin
            get_cnt      <= get_cnt + 1;
            get_cyc      <= cyc;
            mon_get_addr <= get_addr;
        end
    end

    // Data is only meaningful exactly LAT cycles after get_stb; junk otherwise.
    always_comb get_data = stb_hist[LAT-1] ? regs[ahist[LAT-1][7:0]] : {16'hbad0, cyc[15:0]};

    logic [31:0] shadow [256];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_win(input logic [31:0] a);
        return (a >= BASE) && (a <= HIGH);
    endfunction

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 4))
            0, 1:    return BASE + ($urandom_range(0, 63) << 2) + $urandom_range(0, 3);
            2:       return HIGH - $urandom_range(0, 3);
            3:       return BASE - 32'd1 - $urandom_range(0, 255);
            default: return HIGH + 32'd1 + $urandom_range(0, 4095);
        endcase
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly, input string tag);
        bit          aw_done = 0, w_done = 0, stable = 1, ok;
        int          hs_cyc = 0, set0, t;
        logic [31:0] off;
        logic [1:0]  exp_resp;
        ok       = in_win(addr);
        off      = (addr - BASE) >> 2;
        exp_resp = ok ? 2'b00 : 2'b11;
        set0     = set_cnt;
        for (t = 0; t < 64 && !(aw_done && w_done); t++) begin
            @(negedge clk);
            bus.awaddr  = addr;
            bus.awvalid = !aw_done && (t >= aw_dly);
            bus.wdata   = data;
            bus.wstrb   = strb;
            bus.wvalid  = !w_done && (t >= w_dly);
            if (bus.awvalid && bus.awready) begin aw_done = 1; hs_cyc = cyc; end
            if (bus.wvalid && bus.wready) begin w_done = 1; hs_cyc = cyc; end
        end
        check({tag, "/handshake"}, 32'(aw_done && w_done), 32'd1);
        @(negedge clk);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        t = 0;
        while (!bus.bvalid && t < 16) begin @(negedge clk); t++; end
        check({tag, "/bvalid_cycle"}, 32'(cyc), 32'(hs_cyc + 2));
        for (int k = 0; k < b_dly; k++) begin
            stable &= (bus.bvalid === 1'b1) && (bus.bresp === exp_resp) &&
                      (bus.awready === 1'b0) && (bus.wready === 1'b0);
            @(negedge clk);
        end
        check({tag, "/b_hold"}, 32'(stable), 32'd1);
        bus.bready = 1'b1;
        check({tag, "/bresp"}, 32'({bus.bvalid, bus.bresp}), 32'({1'b1, exp_resp}));
        @(negedge clk);
        bus.bready = 1'b0;
        check({tag, "/b_done"}, 32'({bus.bvalid, bus.awready, bus.wready}), 32'b011);
        check({tag, "/set_count"}, 32'(set_cnt - set0), 32'(ok));
        if (ok) begin
            check({tag, "/set_cycle"}, 32'(set_cyc), 32'(hs_cyc + 1));
            check({tag, "/set_addr"}, mon_set_addr, off);
            check({tag, "/set_data"}, mon_set_data, data);
            check({tag, "/set_wstrb"}, 32'(mon_set_wstrb), 32'(strb));
            for (int b = 0; b < 4; b++)
                if (strb[b]) shadow[off[7:0]][8*b +: 8] = data[8*b +: 8];
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_dly,
                           input string tag);
        bit          done = 0, stable = 1, ok;
        int          hs_cyc = 0, get0, t;
        logic [31:0] off, exp_data;
        logic [1:0]  exp_resp;
        ok       = in_win(addr);
        off      = (addr - BASE) >> 2;
        exp_resp = ok ? 2'b00 : 2'b11;
        get0     = get_cnt;
        for (t = 0; t < 64 && !done; t++) begin
            @(negedge clk);
            bus.araddr  = addr;
            bus.arvalid = t >= ar_dly;
            if (bus.arvalid && bus.arready) begin done = 1; hs_cyc = cyc; end
        end
        check({tag, "/handshake"}, 32'(done), 32'd1);
        @(negedge clk);
        bus.arvalid = 1'b0;
        t = 0;
        while (!bus.rvalid && t < 24) begin @(negedge clk); t++; end
        check({tag, "/rvalid_cycle"}, 32'(cyc), 32'(hs_cyc + 2 + LAT));
        exp_data = ok ? shadow[off[7:0]] : 32'h0;
        for (int k = 0; k < r_dly; k++) begin
            stable &= (bus.rvalid === 1'b1) && (bus.rdata === exp_data) &&
                      (bus.rresp === exp_resp) && (bus.arready === 1'b0);
            @(negedge clk);
        end
        check({tag, "/r_hold"}, 32'(stable), 32'd1);
        bus.rready = 1'b1;
        check({tag, "/rdata"}, bus.rdata, exp_data);
        check({tag, "/rresp"}, 32'({bus.rvalid, bus.rresp}), 32'({1'b1, exp_resp}));
        @(negedge clk);
        bus.rready = 1'b0;
        check({tag, "/r_done"}, 32'({bus.rvalid, bus.arready}), 32'b01);
        check({tag, "/get_count"}, 32'(get_cnt - get0), 32'(ok));
        if (ok) begin
            check({tag, "/get_cycle"}, 32'(get_cyc), 32'(hs_cyc + 1));
            check({tag, "/get_addr"}, mon_get_addr, off);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "simulation timeout");
    end

    initial begin
        int          s0, g0;
        bit          quiet;
        logic [31:0] a, d;
        for (int i = 0; i < 256; i++) shadow[i] = 32'h0;
        rst         = 1'b1;
        bus.awaddr  = '0; bus.awvalid = 1'b0; bus.wdata  = '0; bus.wstrb = '0;
        bus.wvalid  = 1'b0; bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst/handshake_outs",
              32'({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, set_stb, get_stb}),
              32'd0);
        check("rst/resp", 32'({bus.bresp, bus.rresp}), 32'd0);
        check("rst/rdata", bus.rdata, 32'd0);
        check("rst/set_addr", set_addr, 32'd0);
        check("rst/set_data", set_data, 32'd0);
        check("rst/get_addr", get_addr, 32'd0);
        check("rst/set_wstrb", 32'(set_wstrb), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst/idle_ready", 32'({bus.awready, bus.wready, bus.arready}), 32'b111);

        // AW first, W three cycles later.
        do_write(BASE + 32'h10, 32'hdead_beef, 4'hf, 0, 3, 0, "wr_aw_first");
        // W first, partial strobe, long BREADY back-pressure.
        do_write(BASE + 32'h24, 32'ha5a5_1234, 4'h3, 4, 0, 10, "wr_w_first");
        // Read with latency, data written through the strobe interface beforehand.
        do_write(BASE + 32'h08, 32'h1234_5678, 4'hf, 1, 1, 0, "wr_pre_read");
        do_read(BASE + 32'h08, 0, 0, "rd_basic");
        check("rd_basic/value", bus.rdata, 32'h1234_5678);
        do_read(BASE + 32'h24, 2, 5, "rd_partial");
        // Out-of-window accesses and window edges.
        do_write(32'h5000_0000, 32'hffff_ffff, 4'hf, 0, 0, 1, "wr_oob");
        do_read(32'h3fff_fffc, 0, 1, "rd_oob_low");
        do_read(HIGH + 32'd1, 0, 0, "rd_oob_high");
        do_write(HIGH, 32'h0bad_cafe, 4'hc, 0, 0, 0, "wr_high_edge");
        do_read(HIGH - 32'd3, 0, 0, "rd_high_edge");
        do_read(BASE, 1, 0, "rd_base_edge");

        // Simultaneous write and read to different registers.
        fork
            do_write(BASE + 32'h40, 32'h0f0f_f0f0, 4'hf, 0, 0, 2, "par_wr");
            do_read(BASE + 32'h10, 0, 1, "par_rd");
        join

        // Reset while the write sits in its response phase and the read is waiting on data.
        @(negedge clk);
        s0 = set_cnt;
        g0 = get_cnt;
        bus.awaddr = BASE + 32'h80; bus.awvalid = 1'b1;
        bus.wdata  = 32'h7777_7777; bus.wstrb = 4'hf; bus.wvalid = 1'b1;
        bus.araddr = BASE + 32'h10; bus.arvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        @(negedge clk);
        check("mid_rst/pre_state", 32'({bus.bvalid, bus.rvalid}), 32'b10);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst/outs",
              32'({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, set_stb, get_stb}),
              32'd0);
        check("mid_rst/rdata", bus.rdata, 32'd0);
        check("mid_rst/set_addr", set_addr, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst/idle_ready", 32'({bus.awready, bus.wready, bus.arready}), 32'b111);
        quiet = 1;
        for (int k = 0; k < 8; k++) begin
            quiet &= !bus.bvalid && !bus.rvalid;
            @(negedge clk);
        end
        check("mid_rst/no_response", 32'(quiet), 32'd1);
        check("mid_rst/set_count", 32'(set_cnt - s0), 32'd1);
        check("mid_rst/get_count", 32'(get_cnt - g0), 32'd1);
        // Register 0x80 was strobed before reset; record it in the model.
        shadow[8'h20] = 32'h7777_7777;

        // Randomized traffic.
        for (int i = 0; i < 30; i++) begin
            a = pick_addr();
            d = $urandom;
            do_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), "rnd_wr");
            if ($urandom_range(0, 1) == 1) a = pick_addr();
            do_read(a, $urandom_range(0, 3), $urandom_range(0, 3), "rnd_rd");
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
